// File: rtl/neuron_buffer_sequencer.sv
// Per-layer read/write address sequencer for the N1/N2 ping-pong neuron buffers.
// Reads stream from one buffer while results land in the other PIPE cycles later.
module neuron_buffer_sequencer #(
  parameter int unsigned A    = 7,
  parameter int unsigned PIPE = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         layerStart,
  input  logic [A-1:0] layerLength,
  input  logic         poolCfg,
  input  logic         stall,
  output logic         readBufferSelect,
  output logic         doPooling,
  output logic [A-1:0] readBuffAddress,
  output logic [A-1:0] writeBuffAddress,
  output logic         nRWrite,
  output logic         nWWrite,
  output logic         busy,
  output logic         layerDone
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e          state_q, state_d;
  logic [A-1:0]    len_q, len_d;
  logic [A-1:0]    rd_addr_q, rd_addr_d;
  logic [A-1:0]    wr_addr_q, wr_addr_d;
  logic            pool_q, pool_d;
  logic            sel_q, sel_d;
  logic            done_q, done_d;
  logic [PIPE-1:0] pipe_q, pipe_d;

  logic            active;
  logic            wr_en;
  logic            last_wr;
  logic [A-1:0]    last_addr;

  assign active    = (state_q != StIdle);
  assign last_addr = len_q - A'(1);
  // Tail of the issue pipe marks a result arriving at the write buffer this cycle.
  assign wr_en     = active & pipe_q[PIPE-1] & ~stall;
  assign last_wr   = wr_en & (wr_addr_q == last_addr);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    pool_d    = pool_q;
    sel_d     = sel_q;
    done_d    = 1'b0;
    pipe_d    = pipe_q;

    unique case (state_q)
      StIdle: begin
        if (layerStart) begin
          if (layerLength != '0) begin
            len_d     = layerLength;
            pool_d    = poolCfg;
            rd_addr_d = '0;
            wr_addr_d = '0;
            pipe_d    = '0;
            state_d   = StRead;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (!stall) begin
          pipe_d = (pipe_q << 1) | PIPE'(1'b1);
          if (rd_addr_q == last_addr) begin
            state_d = StDrain;
          end else begin
            rd_addr_d = rd_addr_q + A'(1);
          end
        end
      end
      StDrain: begin
        if (!stall) begin
          pipe_d = pipe_q << 1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_en) begin
      wr_addr_d = wr_addr_q + A'(1);
    end

    // Final write ends the layer regardless of read progress and swaps buffers.
    if (last_wr) begin
      state_d = StIdle;
      sel_d   = ~sel_q;
      done_d  = 1'b1;
      pipe_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      pool_q    <= 1'b0;
      sel_q     <= 1'b0;
      done_q    <= 1'b0;
      pipe_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      pool_q    <= pool_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
      pipe_q    <= pipe_d;
    end
  end

  assign readBufferSelect = sel_q;
  assign doPooling        = pool_q;
  assign readBuffAddress  = rd_addr_q;
  assign writeBuffAddress = wr_addr_q;
  assign nRWrite          = 1'b0;
  assign nWWrite          = wr_en;
  assign busy             = active;
  assign layerDone        = done_q;

endmodule

// File: tb/tb_neuron_buffer_sequencer.sv
// Directed bench for neuron_buffer_sequencer: cycle-timed checks plus a write-address scoreboard.
module tb_neuron_buffer_sequencer;

  localparam int unsigned A    = 7;
  localparam int unsigned PIPE = 3;

  logic         clk;
  logic         reset;
  logic         layerStart;
  logic [A-1:0] layerLength;
  logic         poolCfg;
  logic         stall;
  logic         readBufferSelect;
  logic         doPooling;
  logic [A-1:0] readBuffAddress;
  logic [A-1:0] writeBuffAddress;
  logic         nRWrite;
  logic         nWWrite;
  logic         busy;
  logic         layerDone;

  int checks = 0;
  int errors = 0;
  logic [A-1:0] wq[$];

  neuron_buffer_sequencer #(
    .A    (A),
    .PIPE (PIPE)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .layerStart       (layerStart),
    .layerLength      (layerLength),
    .poolCfg          (poolCfg),
    .stall            (stall),
    .readBufferSelect (readBufferSelect),
    .doPooling        (doPooling),
    .readBuffAddress  (readBuffAddress),
    .writeBuffAddress (writeBuffAddress),
    .nRWrite          (nRWrite),
    .nWWrite          (nWWrite),
    .busy             (busy),
    .layerDone        (layerDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must consume the next expected write address.
  always @(negedge clk) begin
    if (!reset && nWWrite) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", 32'(writeBuffAddress), 32'hffff_ffff);
      end else begin
        chk("wr_addr", 32'(writeBuffAddress), 32'(wq.pop_front()));
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Runs one layer started in cycle 0; cycle c is the interval after the c-th edge.
  task automatic layer(input int len, input bit pool, input logic [31:0] smask,
                       input int first_wr, input int last_wr, input int done_c,
                       input bit sel_exp, input int restart_c);
    int exp_rd;
    bit exp_wr;
    layerStart  = 1'b1;
    layerLength = A'(len);
    poolCfg     = pool;
    stall       = 1'b0;
    for (int i = 0; i < len; i++) wq.push_back(A'(i));
    @(negedge clk);
    chk("busy_c0", 32'(busy), 32'd0);
    exp_rd = 0;
    for (int c = 1; c <= done_c; c++) begin
      drive_edge();
      layerStart  = (c == restart_c);
      layerLength = (c == restart_c) ? A'(7) : A'(len);
      poolCfg     = (c == restart_c) ? ~pool : pool;
      stall       = smask[c];
      @(negedge clk);
      exp_wr = (c >= first_wr) && (c <= last_wr) && !smask[c];
      chk("nWWrite", 32'(nWWrite), 32'(exp_wr));
      chk("busy", 32'(busy), 32'(c < done_c));
      chk("layerDone", 32'(layerDone), 32'(c == done_c));
      chk("doPooling", 32'(doPooling), 32'(pool));
      chk("rd_addr", 32'(readBuffAddress), 32'(exp_rd));
      chk("sel", 32'(readBufferSelect), 32'((c == done_c) ? sel_exp : !sel_exp));
      chk("nRWrite", 32'(nRWrite), 32'd0);
      if (!smask[c] && exp_rd < len - 1) exp_rd++;
    end
    drive_edge();
    layerStart = 1'b0;
    stall      = 1'b0;
    @(negedge clk);
    chk("done_single_pulse", 32'(layerDone), 32'd0);
    chk("all_writes_seen", 32'(wq.size()), 32'd0);
    drive_edge();
  endtask

  initial begin
    reset       = 1'b1;
    layerStart  = 1'b0;
    layerLength = '0;
    poolCfg     = 1'b0;
    stall       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(layerDone), 32'd0);
    chk("rst_sel", 32'(readBufferSelect), 32'd0);
    chk("rst_wr", 32'(nWWrite), 32'd0);
    chk("rst_rd_addr", 32'(readBuffAddress), 32'd0);
    drive_edge();

    // Basic layer, then a short pooling layer, then a stalled layer.
    layer(4, 1'b0, 32'h0, 4, 7, 8, 1'b1, 0);
    layer(2, 1'b1, 32'h0, 4, 5, 6, 1'b0, 0);
    layer(4, 1'b0, 32'h24, 5, 9, 10, 1'b1, 0);

    // Zero-length start: lone done pulse, no swap, no writes.
    layerStart  = 1'b1;
    layerLength = '0;
    @(negedge clk);
    chk("len0_busy_c0", 32'(busy), 32'd0);
    drive_edge();
    layerStart = 1'b0;
    @(negedge clk);
    chk("len0_done", 32'(layerDone), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_sel", 32'(readBufferSelect), 32'd1);
    chk("len0_wr", 32'(nWWrite), 32'd0);
    drive_edge();
    @(negedge clk);
    chk("len0_done_clear", 32'(layerDone), 32'd0);
    drive_edge();

    // Async reset in DRAIN abandons the layer.
    layerStart  = 1'b1;
    layerLength = A'(4);
    poolCfg     = 1'b1;
    for (int i = 0; i < 4; i++) wq.push_back(A'(i));
    drive_edge();
    layerStart = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_pool", 32'(doPooling), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wr", 32'(nWWrite), 32'd0);
    chk("arst_sel", 32'(readBufferSelect), 32'd0);
    chk("arst_pool", 32'(doPooling), 32'd0);
    chk("arst_rd_addr", 32'(readBuffAddress), 32'd0);
    chk("arst_wr_addr", 32'(writeBuffAddress), 32'd0);
    chk("arst_done", 32'(layerDone), 32'd0);
    wq.delete();
    drive_edge();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 32'(layerDone), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    drive_edge();

    layer(4, 1'b0, 32'h0, 4, 7, 8, 1'b1, 0);
    // Start re-asserted with a different length during READ is ignored.
    layer(4, 1'b1, 32'h0, 4, 7, 8, 1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
